vga_pattern_sequencer: RTL and testbench

- Controls the bar/test-pattern generator: chooses the active pattern and supplies per-pixel bar index and active-area flags.
- Runs in the pixel clock domain. Takes the VGA timing counters (vga_hc/vga_vc, widths `H_SIZE/`V_SIZE from vga_timing.svh).
- Pattern changes happen only at frame boundaries, never mid-frame. A change is triggered by a user request or by an auto-advance timer.

---
 rtl/vga_pattern_pkg.sv | 21 ++
 rtl/vga_pattern_sequencer_if.sv | 30 +++
 rtl/bar_index_counter.sv | 38 +++
 rtl/vga_pattern_sequencer.sv | 117 +++++++++++
 tb/tb_vga_pattern_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared types and defaults for the VGA test-pattern sequencer and the
// pattern generators that consume its outputs.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BAR      = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SOLID    = 2'd3
  } pattern_e;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    SHOW      = 1'b1
  } seq_state_e;

  localparam int HOLD_FRAMES_DEF = 120;
  localparam int H_SIZE_DEF      = 10;
  localparam int V_SIZE_DEF      = 10;

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Bus between the timing generator / user controls and the pattern sequencer.
interface vga_pattern_sequencer_if
  import vga_pattern_pkg::*;
#(
  parameter int H_SIZE   = H_SIZE_DEF,
  parameter int V_SIZE   = V_SIZE_DEF,
  parameter int NUM_BARS = 8
) ();

  logic [H_SIZE-1:0]           vga_hc;
  logic [V_SIZE-1:0]           vga_vc;
  logic                        next_req;
  logic                        auto_en;
  pattern_e                    pattern_sel;
  logic                        pattern_valid;
  logic [$clog2(NUM_BARS)-1:0] bar_idx;
  logic                        active;
  logic [15:0]                 frame_cnt;

  modport master (
    output vga_hc, vga_vc, next_req, auto_en,
    input  pattern_sel, pattern_valid, bar_idx, active, frame_cnt
  );

  modport slave (
    input  vga_hc, vga_vc, next_req, auto_en,
    output pattern_sel, pattern_valid, bar_idx, active, frame_cnt
  );

endinterface

// File: rtl/bar_index_counter.sv
// Maps the horizontal counter to a vertical-bar index, one cycle late.
// The last bar index is held through horizontal blanking.
module bar_index_counter #(
  parameter int H_SIZE   = 10,
  parameter int BAR_W    = 80,
  parameter int NUM_BARS = 8
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic [H_SIZE-1:0]           vga_hc,
  output logic [$clog2(NUM_BARS)-1:0] bar_idx
);

  localparam int PIX_W = $clog2(BAR_W + 1);
  localparam int IDX_W = $clog2(NUM_BARS);

  logic [PIX_W-1:0] pix_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (vga_hc == '0) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_cnt == PIX_W'(BAR_W - 1)) begin
      pix_cnt <= '0;
      if (bar_idx != IDX_W'(NUM_BARS - 1)) begin
        bar_idx <= bar_idx + IDX_W'(1);
      end
    end else begin
      pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Selects the active test pattern, switching only on frame boundaries, and
// provides the per-pixel bar index and active-area flag.
module vga_pattern_sequencer
  import vga_pattern_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int NUM_BARS     = 8,
  parameter int BAR_W        = H_ACTIVE / NUM_BARS,
  parameter int H_SIZE       = H_SIZE_DEF,
  parameter int V_SIZE       = V_SIZE_DEF
) (
  input logic                    pixel_clk,
  input logic                    reset,
  vga_pattern_sequencer_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  seq_state_e        state_q, state_d;
  pattern_e          sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pending_q, pending_d;
  logic              active_q;
  logic              frame_start;
  logic              hold_done;
  logic              advance;

  assign frame_start = (bus.vga_hc == '0) && (bus.vga_vc == '0);
  assign hold_done   = bus.auto_en && (hold_q == HOLD_W'(HOLD_FRAMES - 1));

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      sel_q       <= PAT_BAR;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      active_q    <= (bus.vga_hc < H_SIZE'(H_ACTIVE)) &&
                     (bus.vga_vc < V_SIZE'(V_ACTIVE));
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    advance     = 1'b0;

    unique case (state_q)
      WAIT_SYNC: begin
        pending_d = 1'b0;
        if (frame_start) begin
          state_d     = SHOW;
          valid_d     = 1'b1;
          frame_cnt_d = 16'd1;
        end
      end
      SHOW: begin
        if (bus.next_req) begin
          pending_d = 1'b1;
        end
        if (frame_start) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          // A request landing on the boundary cycle itself counts for this frame.
          advance = pending_q || bus.next_req || hold_done;
          if (advance) begin
            sel_d     = (sel_q == pattern_e'(NUM_PATTERNS - 1)) ? PAT_BAR
                                                                 : pattern_e'(sel_q + 2'd1);
            hold_d    = '0;
            pending_d = 1'b0;
          end else if (bus.auto_en) begin
            hold_d = hold_q + HOLD_W'(1);
          end else begin
            hold_d = '0;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  bar_index_counter #(
    .H_SIZE   (H_SIZE),
    .BAR_W    (BAR_W),
    .NUM_BARS (NUM_BARS)
  ) u_bar_index_counter (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .vga_hc    (bus.vga_hc),
    .bar_idx   (bus.bar_idx)
  );

  assign bus.pattern_sel   = sel_q;
  assign bus.pattern_valid = valid_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.active        = active_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer on a 20x6 miniature raster
// (16x4 visible, 4 bars of 4 pixels, 3-frame auto hold).
module tb_vga_pattern_sequencer;
  import vga_pattern_pkg::*;

  localparam int H_SIZE       = 5;
  localparam int V_SIZE       = 3;
  localparam int H_TOTAL      = 20;
  localparam int V_TOTAL      = 6;
  localparam int H_ACTIVE     = 16;
  localparam int V_ACTIVE     = 4;
  localparam int NUM_BARS     = 4;
  localparam int BAR_W        = 4;
  localparam int HOLD_FRAMES  = 3;
  localparam int NUM_PATTERNS = 4;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   failures  = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_pattern_sequencer_if #(
    .H_SIZE   (H_SIZE),
    .V_SIZE   (V_SIZE),
    .NUM_BARS (NUM_BARS)
  ) bus ();

  vga_pattern_sequencer #(
    .NUM_PATTERNS (NUM_PATTERNS),
    .HOLD_FRAMES  (HOLD_FRAMES),
    .H_ACTIVE     (H_ACTIVE),
    .V_ACTIVE     (V_ACTIVE),
    .NUM_BARS     (NUM_BARS),
    .BAR_W        (BAR_W),
    .H_SIZE       (H_SIZE),
    .V_SIZE       (V_SIZE)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one raster position for one clock; outputs are read 1 ns after the edge.
  task automatic do_cycle(input int h, input int v, input logic req);
    bus.vga_hc   = H_SIZE'(h);
    bus.vga_vc   = V_SIZE'(v);
    bus.next_req = req;
    @(posedge pixel_clk);
    #1;
    bus.next_req = 1'b0;
  endtask

  // Walk the raster from (v0,h0) to the end of line v1; nreq spaced one-cycle
  // request pulses are placed on line 3 at hc 1, 5, 9, ...
  task automatic body(input int v0, input int h0, input int v1, input int nreq);
    for (int v = v0; v <= v1; v++) begin
      for (int h = (v == v0) ? h0 : 0; h < H_TOTAL; h++) begin
        do_cycle(h, v, (v == 3) && (h % 4 == 1) && (h / 4 < nreq));
      end
    end
  endtask

  task automatic frame_start_check(input int f, input logic req, input int exp_sel,
                                   input int exp_fc);
    do_cycle(0, 0, req);
    check($sformatf("sel_f%0d", f), 32'(bus.pattern_sel), 32'(exp_sel));
    check($sformatf("frame_cnt_f%0d", f), 32'(bus.frame_cnt), 32'(exp_fc));
    check($sformatf("valid_f%0d", f), 32'(bus.pattern_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sel[18];
    exp_sel = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 0, 0, 1, 1, 1, 2};

    bus.vga_hc   = '0;
    bus.vga_vc   = '0;
    bus.next_req = 1'b0;
    bus.auto_en  = 1'b0;

    // Reset held for five cycles in the middle of a frame.
    for (int h = 7; h < 12; h++) do_cycle(h, 2, 1'b0);
    check("rst_sel", 32'(bus.pattern_sel), 32'd0);
    check("rst_valid", 32'(bus.pattern_valid), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst_bar_idx", 32'(bus.bar_idx), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);

    // Rest of the frame in WAIT_SYNC, including two requests that must be ignored.
    reset = 1'b0;
    body(2, 12, V_TOTAL - 1, 2);
    check("sync_valid", 32'(bus.pattern_valid), 32'd0);
    check("sync_sel", 32'(bus.pattern_sel), 32'd0);
    check("sync_frame_cnt", 32'(bus.frame_cnt), 32'd0);

    // Frame 1: first boundary, then a full line sweep of the bar counter.
    frame_start_check(1, 1'b0, 0, 1);
    check("bar_hc0", 32'(bus.bar_idx), 32'd0);
    check("active_hc0", 32'(bus.active), 32'd1);
    for (int h = 1; h < H_TOTAL; h++) begin
      do_cycle(h, 0, 1'b0);
      check($sformatf("bar_hc%0d", h), 32'(bus.bar_idx), (h < 16) ? 32'(h / 4) : 32'd3);
      check($sformatf("active_hc%0d", h), 32'(bus.active), (h < 16) ? 32'd1 : 32'd0);
    end
    body(1, 0, V_TOTAL - 1, 0);

    // Frame 2: three requests collapse into one advance at frame 3.
    frame_start_check(2, 1'b0, 0, 2);
    body(0, 1, 3, 3);
    check("sel_midframe", 32'(bus.pattern_sel), 32'd0);
    do_cycle(0, 4, 1'b0);
    check("active_vc4", 32'(bus.active), 32'd0);
    check("bar_vc4_hc0", 32'(bus.bar_idx), 32'd0);
    body(4, 1, V_TOTAL - 1, 0);

    // Frames 3..17: boundary request at f5, auto mode from f7, manual step in f13.
    for (int f = 3; f <= 17; f++) begin
      bus.auto_en = (f >= 7);
      frame_start_check(f, f == 5, exp_sel[f], f);
      body(0, 1, V_TOTAL - 1, (f == 13) ? 1 : 0);
    end

    // Frame 18: a request leaves pending set, then reset arrives mid-frame.
    bus.auto_en = 1'b0;
    frame_start_check(18, 1'b0, 2, 18);
    body(0, 1, 3, 1);
    reset = 1'b1;
    body(4, 0, 4, 0);
    check("rst2_sel", 32'(bus.pattern_sel), 32'd0);
    check("rst2_valid", 32'(bus.pattern_valid), 32'd0);
    check("rst2_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    reset = 1'b0;
    body(5, 0, V_TOTAL - 1, 0);

    // Re-sync; the stale request must not advance the pattern.
    frame_start_check(101, 1'b0, 0, 1);
    body(0, 1, V_TOTAL - 1, 0);
    frame_start_check(102, 1'b0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
